// File: rtl/srl32_lane_loader.sv
// rtl/srl32_lane_loader.sv - round-robin loader and readback checker for three SRLC32E lanes
module srl32_lane_loader #(
    parameter int LANES = 3,
    parameter int DEPTH = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [LANES-1:0]       req,
    input  logic [DEPTH*LANES-1:0] req_data,
    output logic [LANES-1:0]       gnt,
    output logic [LANES-1:0]       done,
    output logic                   pass,
    output logic                   busy,
    output logic                   srl_d,
    output logic [LANES-1:0]       srl_ce,
    output logic [4:0]             srl_a,
    input  logic [LANES-1:0]       srl_q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [4:0] LAST = 5'(DEPTH - 1);

    state_t           state, state_n;
    logic [4:0]       cnt, cnt_n;
    logic             err, err_n;
    logic [1:0]       lane, lane_n;
    logic [1:0]       ptr, ptr_n;
    logic [DEPTH-1:0] word, word_n;

    logic [LANES-1:0] gnt_n, done_n, ce_n;
    logic             pass_n, busy_n, d_n;
    logic [4:0]       a_n;

    logic [1:0]       pick;
    logic [DEPTH-1:0] pick_word;
    logic             mismatch;

    // First requesting lane at or after the round-robin pointer.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] sel;
        case (p)
            2'd1:    sel = r[1] ? 2'd1 : (r[2] ? 2'd2 : 2'd0);
            2'd2:    sel = r[2] ? 2'd2 : (r[0] ? 2'd0 : 2'd1);
            default: sel = r[0] ? 2'd0 : (r[1] ? 2'd1 : 2'd2);
        endcase
        return sel;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] l);
        logic [2:0] v;
        case (l)
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b001;
        endcase
        return v;
    endfunction

    assign pick      = rr_pick(req, ptr);
    assign pick_word = req_data[DEPTH*pick +: DEPTH];
    assign mismatch  = (srl_q[lane] != word[cnt]);

    // State, datapath and every output are registered together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            err    <= 1'b0;
            lane   <= '0;
            ptr    <= '0;
            word   <= '0;
            gnt    <= '0;
            done   <= '0;
            pass   <= 1'b0;
            busy   <= 1'b0;
            srl_d  <= 1'b0;
            srl_ce <= '0;
            srl_a  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            err    <= err_n;
            lane   <= lane_n;
            ptr    <= ptr_n;
            word   <= word_n;
            gnt    <= gnt_n;
            done   <= done_n;
            pass   <= pass_n;
            busy   <= busy_n;
            srl_d  <= d_n;
            srl_ce <= ce_n;
            srl_a  <= a_n;
        end
    end

    // Next-state logic; output values are those the registers show next cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err;
        lane_n  = lane;
        ptr_n   = ptr;
        word_n  = word;
        gnt_n   = '0;
        done_n  = '0;
        ce_n    = '0;
        pass_n  = 1'b0;
        busy_n  = 1'b0;
        d_n     = 1'b0;
        a_n     = '0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    lane_n  = pick;
                    word_n  = pick_word;
                    ptr_n   = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                    gnt_n   = onehot(pick);
                    ce_n    = onehot(pick);
                    d_n     = pick_word[DEPTH-1];
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                busy_n = 1'b1;
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = S_READ;
                end else begin
                    cnt_n = cnt + 5'd1;
                    ce_n  = onehot(lane);
                    d_n   = word[LAST - 5'd1 - cnt];
                end
            end
            S_READ: begin
                busy_n = 1'b1;
                err_n  = err | mismatch;
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    done_n  = onehot(lane);
                    pass_n  = ~(err | mismatch);
                    state_n = S_DONE;
                end else begin
                    cnt_n = cnt + 5'd1;
                    a_n   = cnt + 5'd1;
                end
            end
            default: begin
                err_n   = 1'b0;
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/srl32_lane_loader.md
Name: srl32_lane_loader

Overview:
- Shared controller for three SRLC32E lanes placed in one slice (A6LUT/B6LUT/C6LUT).
- The lanes share one serial data input and one read address; each lane has its own clock enable.
- Three requesters each ask to load a 32-bit pattern into their own lane. The block arbitrates round-robin, shifts the pattern in, reads all 32 taps back, and reports pass/fail per lane.
- Used as the loading and self-check engine in SRL fuzzer and minitest designs.

Parameters:
- LANES, 3, number of SRL lanes and requesters (fixed 3 for this slice arrangement).
- DEPTH, 32, SRL depth. Address width is 5 bits; a non-32 value is unsupported.

Ports:
- CLK  input  1  single clock, drives the SRLs and the controller.
- RST  input  1  asynchronous, active-high reset.
- req  input  3  per-lane load request; level, held until gnt.
- req_data  input  96  lane i pattern at bits [32*i+31:32*i]; sampled on the grant edge.
- gnt  output  3  one-hot, 1-cycle pulse: request accepted.
- done  output  3  one-hot, 1-cycle pulse: lane operation finished.
- pass  output  1  valid only while done is nonzero; 1 means every tap matched.
- busy  output  1  high whenever state is not IDLE.
- srl_d  output  1  shared SRL D.
- srl_ce  output  3  per-lane SRL CE; at most one bit set.
- srl_a  output  5  shared SRL A.
- srl_q  input  3  SRL Q, one bit per lane.

Behaviour:
- Reset state: all outputs 0, state IDLE, RR pointer 0.
- States: IDLE -> LOAD -> READ -> DONE -> IDLE.
- All outputs are registered.
- SRL semantics: on a CLK edge with CE=1, tap0<=D and tap[k]<=tap[k-1]. Q = tap[A] combinationally.
- Loading order makes tap k equal W[k]: shift W[31] first and W[0] last.
- IDLE, on any req at an edge:
  - Grant lane L, the first requesting lane at or after the pointer (mod 3).
  - Latch W=req_data[L]. Pointer <= (L+1) mod 3.
  - Next cycle (cycle 0): gnt[L]=1, state LOAD, srl_ce[L]=1, srl_d=W[31], cnt=0.
- LOAD, cycles 0..31:
  - srl_ce[L]=1 and srl_d=W[31-cnt].
  - After cycle 31: srl_ce=0, state READ, cnt=0.
- READ, cycles 32..63:
  - srl_a=cnt.
  - At the end-of-cycle edge, compare srl_q[L] with W[cnt]. Any mismatch sets a sticky err.
  - srl_q of other lanes is ignored.
- DONE, cycle 64: done[L]=1, pass=~err. Then IDLE, with err, srl_a and cnt cleared.
- Timing summary:
  - Latency from gnt to done is 64 cycles.
  - busy is high in cycles 0..64.
  - The earliest next gnt is cycle 66.
- Outside LOAD: srl_ce=0 and srl_d=0. Outside READ: srl_a=0.
- Request handling:
  - A req deasserted before grant is never granted.
  - A req still high after its done competes again under round-robin.
  - Requests arriving while busy wait; they are not queued beyond their level.
- Reset mid-operation (asynchronous):
  - All outputs go to 0 immediately, including srl_ce, so no further shifting.
  - No done pulse is issued for the aborted lane. Its SRL contents are undefined.
  - Pointer returns to 0.
- srl_a and cnt are 5-bit and never wrap within a phase; the phase ends at cnt=31.

Test Plan:
- Single load: req=3'b001, lane0 data 0xDEADBEEF, bench SRL model -> gnt=001 in cycle 0; srl_ce[0] high exactly in cycles 0..31; srl_d sequence equals bits 31..0 of 0xDEADBEEF; done=001 in cycle 64 with pass=1; busy low in cycle 65.
- Bit-order check: lane1 data 0x00000001 -> srl_d=1 only in cycle 31; model tap0=1 and taps 1..31=0; pass=1. Repeat with 0x80000000 -> srl_d=1 only in cycle 0; pass=1.
- Fault injection: model forces srl_q[2] inverted when srl_a=7; lane2 data 0x12345678 -> done=100 with pass=0. A following clean lane2 run -> pass=1, proving err cleared.
- Arbitration: req=3'b111 held, each requester dropping req on its gnt -> grants in order 001, 010, 100, 66 cycles apart. Then req=3'b011 together -> grant 001 first (pointer wrapped to 0), then 010.
- Reset in LOAD cycle 10 -> same cycle: srl_ce=0, busy=0, gnt=0, no done. After release, req=3'b010 -> granted 010, normal 64-cycle completion with pass=1.
- Contention while busy: lane0 running, req[1] rises in cycle 20 -> gnt=010 only in cycle 66; srl_ce never has two bits set at any time.
